conv_bram_sr_kpar_dpath: RTL
============================

CONV_BRAM_SR_KPAR_DPATH -- requirements
Module: conv_bram_sr_kpar_dpath

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, signed pixel/weight/result width.
REQ-002 SHALL have parameters IMG_W 16, IMG_H 16, IMG_D 32: image width, height, channels.
REQ-003 SHALL have parameters FILTER_L 3 (square filter side) and FILTER_K 8 (filters computed in parallel).
REQ-004 SHALL have parameters STRIDE_W 1, STRIDE_H 1; derived RESULT_W=(IMG_W-FILTER_L)/STRIDE_W+1, RESULT_H=(IMG_H-FILTER_L)/STRIDE_H+1, N=FILTER_L*FILTER_L*IMG_D, ACC_W=2*DATA_WIDTH+clog2(N).
REQ-005 SHALL have ports clk (in, 1, clock) and reset (in, 1, reset); one clock; reset asynchronous, active-high.
REQ-006 dpath_wren in 1: shift one new column (FILTER_L pixels per channel) into every window.
REQ-007 dpath_row_start in 1: qualifies dpath_wren; the column is the first of a new output row.
REQ-008 dpath_rotation_offset in clog2(FILTER_L): circular line-buffer row rotation, applied combinationally to img_data_in.
REQ-009 img_data_in in DATA_WIDTH*IMG_D*FILTER_L: one column, channel i in slice i.
REQ-010 fil in DATA_WIDTH*IMG_D*FILTER_L*FILTER_L*FILTER_K: weights, filter k in slice k, held stable by the caller.
REQ-011 result_data_out out DATA_WIDTH*FILTER_K: one result per filter, filter k in slice k.
REQ-012 result_wraddress out clog2(RESULT_W*RESULT_H); result_wren out 1; last_val out 1.

Function
REQ-013 Per channel SHALL keep a FILTER_L x FILTER_L shift-register window; on dpath_wren all columns shift by one, the rotated column enters, the oldest is discarded.
REQ-014 SHALL count columns in col_cnt (saturating at FILTER_L+STRIDE_W); dpath_wren with dpath_row_start sets col_cnt=1, plain dpath_wren increments.
REQ-015 After the shift, a window is issued when col_cnt==FILTER_L, then every STRIDE_W further columns (stride phase counter, reset on row_start).
REQ-016 Each issued window SHALL be multiplied element-wise by each filter, signed, products summed in a binary pipelined tree at ACC_W bits, no intermediate truncation.
REQ-017 Latency from issuing dpath_wren edge to result_wren SHALL be LAT=clog2(N)+2 cycles (shift register, multiplier register, one register per tree level, output register), fully pipelined, one issue per cycle max.
REQ-018 Output SHALL saturate the ACC_W sum to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-019 result_wraddress SHALL come from an internal counter starting at 0, incremented per issued window, wrapping to 0 after RESULT_W*RESULT_H-1; address travels with data through the pipeline.
REQ-020 last_val SHALL be high exactly in the cycle result_wren is high with result_wraddress==RESULT_W*RESULT_H-1.
REQ-021 dpath_wren low SHALL hold windows, counters unchanged; in-flight pipeline results still drain.
REQ-022 dpath_row_start without dpath_wren SHALL be ignored.
REQ-023 Skipping of rows for STRIDE_H>1 is the controller's job; the block only issues per REQ-015.

Reset
REQ-024 reset SHALL asynchronously clear windows, col_cnt, stride phase, address counter, all pipeline valids and data; result_data_out=0, result_wraddress=0, result_wren=0, last_val=0.
REQ-025 reset mid-frame SHALL drop all in-flight results; no result_wren until LAT cycles after the first post-reset issue.

Configuration
REQ-026 Macro CONV_DPATH_RELU_EN defined: negative sums SHALL clamp to 0 before saturation; undefined: signed output per REQ-018 only.

Verification
REQ-027 FILTER_L=3, IMG_D=1, all pixels 1, all weights 1, row_start then 3 wren -> one result 9 at address 0 after LAT cycles.
REQ-028 STRIDE_W=2, IMG_W=16: row of 16 columns -> 7 results, issued after columns 3,5,...,15, addresses 0..6.
REQ-029 Pixels 2047, weights 2047, DATA_WIDTH=12 -> output 2047 (saturated); weights -2047 -> -2048, or 0 with CONV_DPATH_RELU_EN.
REQ-030 Full 16x16 frame, STRIDE 1 -> 196 results per filter, last_val once at address 195, next frame restarts at 0.
REQ-031 Assert reset 2 cycles after an issue -> outputs 0 immediately, no stale result_wren.
REQ-032 FILTER_K=2, filter 1 weights negated filter 0, dpath_rotation_offset=1 vs. pre-rotated input -> equal, opposite-sign results.

Source files
------------

// File: rtl/conv_bram_sr_kpar_dpath.sv
// conv_bram_sr_kpar_dpath: FILTER_K-parallel conv datapath, per-channel shift-register windows, pipelined adder trees.
// Define CONV_DPATH_RELU_EN to clamp negative sums to 0; element e=(c*FILTER_L+r)*FILTER_L+col, col 0 oldest.
module conv_bram_sr_kpar_dpath #(
  parameter int DATA_WIDTH = 12,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  parameter int IMG_D = 32,
  parameter int FILTER_L = 3,
  parameter int FILTER_K = 8,
  parameter int STRIDE_W = 1,
  parameter int STRIDE_H = 1,
  localparam int RESULT_W = (IMG_W - FILTER_L) / STRIDE_W + 1,
  localparam int RESULT_H = (IMG_H - FILTER_L) / STRIDE_H + 1,
  localparam int NRES = RESULT_W * RESULT_H,
  localparam int N = FILTER_L * FILTER_L * IMG_D,
  localparam int LVLS = $clog2(N),
  localparam int ACC_W = 2 * DATA_WIDTH + LVLS,
  localparam int ADDR_W = NRES > 1 ? $clog2(NRES) : 1,
  localparam int OFF_W = FILTER_L > 1 ? $clog2(FILTER_L) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  dpath_wren,
  input  logic                                  dpath_row_start,
  input  logic [OFF_W-1:0]                      dpath_rotation_offset,
  input  logic [DATA_WIDTH*IMG_D*FILTER_L-1:0]  img_data_in,
  input  logic [DATA_WIDTH*N*FILTER_K-1:0]      fil,
  output logic [DATA_WIDTH*FILTER_K-1:0]        result_data_out,
  output logic [ADDR_W-1:0]                     result_wraddress,
  output logic                                  result_wren,
  output logic                                  last_val
);
  localparam int P = 1 << LVLS;
  localparam int CW = $clog2(FILTER_L + STRIDE_W + 1);
  localparam int SW = STRIDE_W > 1 ? $clog2(STRIDE_W) : 1;
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [ACC_W-1:0] MINV = -MAXV - ACC_W'(1);
  logic signed [DATA_WIDTH-1:0]   w_col  [IMG_D][FILTER_L];
  logic signed [DATA_WIDTH-1:0]   r_win  [IMG_D][FILTER_L][FILTER_L];
  logic signed [2*DATA_WIDTH-1:0] w_prod [FILTER_K][N];
  // heap-ordered tree: leaves P..2P-1 are the product registers, node 1 is the root
  logic signed [ACC_W-1:0]        r_node [FILTER_K][1:2*P-1];
  logic signed [ACC_W-1:0]        w_sum  [FILTER_K];
  logic signed [DATA_WIDTH-1:0]   w_sat  [FILTER_K];
  logic [CW-1:0]                  r_col_cnt, w_cnt_n;
  logic [SW-1:0]                  r_ph, w_ph_n;
  logic                           w_issue;
  logic [ADDR_W-1:0]              r_addr;
  logic [LVLS+1:0]                r_vp;
  logic [ADDR_W-1:0]              r_ap [LVLS+2];
  always_comb begin
    // rotated row r takes input row (r + offset) % FILTER_L
    for (int c = 0; c < IMG_D; c++)
      for (int r = 0; r < FILTER_L; r++)
        w_col[c][r] = img_data_in[(c*FILTER_L + (r + int'(dpath_rotation_offset)) % FILTER_L)*DATA_WIDTH +: DATA_WIDTH];
    for (int k = 0; k < FILTER_K; k++) begin
      for (int e = 0; e < N; e++)
        w_prod[k][e] = r_win[e/(FILTER_L*FILTER_L)][(e/FILTER_L)%FILTER_L][e%FILTER_L] * $signed(fil[(k*N+e)*DATA_WIDTH +: DATA_WIDTH]);
      w_sum[k] = r_node[k][1];
`ifdef CONV_DPATH_RELU_EN
      w_sum[k] = w_sum[k][ACC_W-1] ? '0 : w_sum[k];
`endif
      w_sat[k] = w_sum[k] > MAXV ? MAXV[DATA_WIDTH-1:0] : w_sum[k] < MINV ? MINV[DATA_WIDTH-1:0] : w_sum[k][DATA_WIDTH-1:0];
    end
    w_cnt_n = dpath_row_start ? CW'(1) : (r_col_cnt == CW'(FILTER_L + STRIDE_W) ? r_col_cnt : r_col_cnt + CW'(1));
    w_ph_n = (w_cnt_n <= CW'(FILTER_L) || r_ph == SW'(STRIDE_W - 1)) ? '0 : r_ph + SW'(1);
    w_issue = dpath_wren && (w_cnt_n == CW'(FILTER_L) || (w_cnt_n > CW'(FILTER_L) && w_ph_n == '0));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win <= '{default: '0};
      r_node <= '{default: '0};
      r_col_cnt <= '0;
      r_ph <= '0;
      r_addr <= '0;
      r_vp <= '0;
      r_ap <= '{default: '0};
      result_data_out <= '0;
      result_wraddress <= '0;
      result_wren <= 1'b0;
      last_val <= 1'b0;
    end else begin
      if (dpath_wren) begin
        for (int c = 0; c < IMG_D; c++)
          for (int r = 0; r < FILTER_L; r++) begin
            for (int j = 0; j < FILTER_L - 1; j++)
              r_win[c][r][j] <= r_win[c][r][j+1];
            r_win[c][r][FILTER_L-1] <= w_col[c][r];
          end
        r_col_cnt <= w_cnt_n;
        r_ph <= w_ph_n;
      end
      if (w_issue)
        r_addr <= r_addr == ADDR_W'(NRES - 1) ? '0 : r_addr + ADDR_W'(1);
      r_vp <= {r_vp[LVLS:0], w_issue};
      r_ap[0] <= r_addr;
      for (int j = 1; j <= LVLS + 1; j++)
        r_ap[j] <= r_ap[j-1];
      for (int k = 0; k < FILTER_K; k++) begin
        for (int e = 0; e < P; e++)
          r_node[k][P+e] <= e < N ? ACC_W'(w_prod[k][e < N ? e : 0]) : '0;
        for (int i = 1; i < P; i++)
          r_node[k][i] <= r_node[k][2*i] + r_node[k][2*i+1];
        result_data_out[k*DATA_WIDTH +: DATA_WIDTH] <= w_sat[k];
      end
      result_wren <= r_vp[LVLS+1];
      result_wraddress <= r_ap[LVLS+1];
      last_val <= r_vp[LVLS+1] && r_ap[LVLS+1] == ADDR_W'(NRES - 1);
    end
  end
endmodule
